// File: rtl/scv_video_pkg.sv
// Shared types, default raster timing and helpers for the SCV video front end.
package scv_video_pkg;

  // Raster counters are 9 bits: enough for 260 pixels and 262 lines.
  typedef logic [8:0] hcnt_t;
  typedef logic [8:0] vcnt_t;

  // CPU-side base of the shared VRAM window; the fetch port carries offsets only.
  localparam logic [15:0] VRAM_BASE = 16'h3000;

  // Default NTSC-like raster timing.
  localparam int DEF_CE_DIV       = 1;
  localparam int DEF_H_TOTAL      = 260;
  localparam int DEF_H_ACTIVE     = 192;
  localparam int DEF_H_SYNC_START = 216;
  localparam int DEF_H_SYNC_LEN   = 20;
  localparam int DEF_V_TOTAL      = 262;
  localparam int DEF_V_ACTIVE     = 222;
  localparam int DEF_V_SYNC_START = 240;
  localparam int DEF_V_SYNC_LEN   = 3;

  // Background fetch FSM: idle, or holding a request until the arbiter grants it.
  typedef enum logic {
    IDLE,
    WAIT
  } fetch_state_t;

  // Tile-map entry for an 8x8 cell: rows of 32 cells, taken relative to the
  // VRAM window so the port sees a 10-bit offset.
  function automatic logic [9:0] tile_offset(input logic [4:0] row, input logic [4:0] col);
    logic [15:0] cpu_addr;
    cpu_addr = VRAM_BASE + {6'd0, row, col};
    return 10'(cpu_addr - VRAM_BASE);
  endfunction

endpackage

// File: rtl/scv_vram_fetch.sv
// Tile-map fetch engine: one outstanding VRAM request, replaced (and flagged
// late) if the next slot arrives before the arbiter grants the current one.
module scv_vram_fetch
  import scv_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slot,
  input  logic [9:0] slot_addr,
  input  logic       vram_ack,
  input  logic [7:0] vram_di,
  input  logic       late_clr,
  output logic       vram_req,
  output logic [9:0] vram_a,
  output logic [7:0] tile_q,
  output logic       tile_valid,
  output logic       fetch_late
);

  fetch_state_t state;

  // Request/grant FSM with registered request, address, tile byte and late flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vram_req   <= 1'b0;
      vram_a     <= '0;
      tile_q     <= '0;
      tile_valid <= 1'b0;
      fetch_late <= 1'b0;
    end else begin
      tile_valid <= 1'b0;
      // A new late event later in this block overrides the clear.
      if (late_clr) fetch_late <= 1'b0;

      case (state)
        IDLE: begin
          // Grants arriving with no request outstanding are ignored.
          if (slot) begin
            vram_a   <= slot_addr;
            vram_req <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (vram_ack) begin
            tile_q     <= vram_di;
            tile_valid <= 1'b1;
            if (slot) begin
              // Grant and next slot coincide: old fetch completes, new one starts.
              vram_a <= slot_addr;
            end else begin
              vram_req <= 1'b0;
              state    <= IDLE;
            end
          end else if (slot) begin
            // Arbiter never granted in time: abandon the byte, chase the new cell.
            fetch_late <= 1'b1;
            vram_a     <= slot_addr;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/scv_video_timing.sv
// SCV raster timing: pixel-enable divider, pixel/line counters, sync and
// blank decodes, and the per-cell slot strobe feeding the tile-map fetcher.
module scv_video_timing
  import scv_video_pkg::*;
#(
  parameter int CE_DIV       = DEF_CE_DIV,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_ce,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       vbl,
  output logic       frame_start,
  output logic       vram_req,
  output logic [9:0] vram_a,
  input  logic       vram_ack,
  input  logic [7:0] vram_di,
  output logic [7:0] tile_q,
  output logic       tile_valid,
  output logic       fetch_late,
  input  logic       late_clr
);

  localparam logic [3:0] DIV_LAST  = 4'(CE_DIV - 1);
  localparam hcnt_t      H_LAST    = hcnt_t'(H_TOTAL - 1);
  localparam vcnt_t      V_LAST    = vcnt_t'(V_TOTAL - 1);
  localparam hcnt_t      H_ACT     = hcnt_t'(H_ACTIVE);
  localparam vcnt_t      V_ACT     = vcnt_t'(V_ACTIVE);
  localparam hcnt_t      HSYNC_LO  = hcnt_t'(H_SYNC_START);
  localparam hcnt_t      HSYNC_HI  = hcnt_t'(H_SYNC_START + H_SYNC_LEN);
  localparam vcnt_t      VSYNC_LO  = vcnt_t'(V_SYNC_START);
  localparam vcnt_t      VSYNC_HI  = vcnt_t'(V_SYNC_START + V_SYNC_LEN);

  logic [3:0] div_cnt;
  logic       slot;
  logic [9:0] slot_addr;

  // Pixel divider; pix_ce is registered the cycle after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      pix_ce  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end
  end

  // Pixel and line counters; frame_start marks entry into 0/0 after a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          if (vcnt == V_LAST) begin
            vcnt        <= '0;
            frame_start <= 1'b1;
          end else begin
            vcnt <= vcnt + 9'd1;
          end
        end else begin
          hcnt <= hcnt + 9'd1;
        end
      end
    end
  end

  // Sync and blank are pure decodes of the registered counters.
  assign hsync  = (hcnt >= HSYNC_LO) && (hcnt < HSYNC_HI);
  assign vsync  = (vcnt >= VSYNC_LO) && (vcnt < VSYNC_HI);
  assign hblank = (hcnt >= H_ACT);
  assign vblank = (vcnt >= V_ACT);
  assign vbl    = vblank;

  // One fetch slot at the first pixel of each visible 8-pixel cell.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    slot = 1'b0;
    if (pix_ce && (hcnt[2:0] == 3'd0) && (hcnt < H_ACT) && (vcnt < V_ACT)) slot = 1'b1;
  end

  assign slot_addr = tile_offset(vcnt[7:3], hcnt[7:3]);

  scv_vram_fetch u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot       (slot),
    .slot_addr  (slot_addr),
    .vram_ack   (vram_ack),
    .vram_di    (vram_di),
    .late_clr   (late_clr),
    .vram_req   (vram_req),
    .vram_a     (vram_a),
    .tile_q     (tile_q),
    .tile_valid (tile_valid),
    .fetch_late (fetch_late)
  );

endmodule

// File: tb/tb_scv_video_timing.sv
// Bench for scv_video_timing: instance A (CE_DIV=1) against a cycle-indexed
// reference model under directed and random grant traffic, instance B
// (CE_DIV=4) for divider cadence, instance C for a mid-fetch async reset.
`timescale 1ns/1ps
module tb_scv_video_timing;

  localparam int H_TOT    = 260;
  localparam int V_TOT    = 262;
  localparam int FRAME    = H_TOT * V_TOT;
  localparam int A_CYCLES = FRAME + 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Pixel advances completed after n clock edges since reset release.
  function automatic int pix_adv(input int n, input int d);
    return (n >= 1) ? (n - 1) / d : 0;
  endfunction

  function automatic bit exp_ce(input int n, input int d);
    return (n >= 1) && (n % d == 0);
  endfunction

  function automatic bit exp_fs(input int n, input int d);
    int p;
    p = pix_adv(n, d);
    return (n >= 2) && ((n - 1) % d == 0) && (p > 0) && (p % FRAME == 0);
  endfunction

  // ---------------- instance A: CE_DIV = 1 ----------------
  logic       rst_n;
  logic       a_pix_ce, a_hsync, a_vsync, a_hblank, a_vblank, a_vbl, a_frame_start;
  logic [8:0] a_hcnt, a_vcnt;
  logic       a_req, a_ack, a_tile_valid, a_late, a_late_clr;
  logic [9:0] a_vram_a;
  logic [7:0] a_di, a_tile_q;

  scv_video_timing #(.CE_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_ce(a_pix_ce), .hcnt(a_hcnt), .vcnt(a_vcnt),
    .hsync(a_hsync), .vsync(a_vsync), .hblank(a_hblank), .vblank(a_vblank), .vbl(a_vbl),
    .frame_start(a_frame_start), .vram_req(a_req), .vram_a(a_vram_a), .vram_ack(a_ack),
    .vram_di(a_di), .tile_q(a_tile_q), .tile_valid(a_tile_valid), .fetch_late(a_late),
    .late_clr(a_late_clr)
  );

  // ---------------- instance B: CE_DIV = 4 ----------------
  logic       b_pix_ce, b_hsync, b_vsync, b_hblank, b_vblank, b_vbl, b_frame_start;
  logic [8:0] b_hcnt, b_vcnt;
  logic       b_req, b_tile_valid, b_late;
  logic [9:0] b_vram_a;
  logic [7:0] b_tile_q;
  logic       b_ack = 1'b0;
  logic       b_late_clr = 1'b0;
  logic [7:0] b_di = 8'h00;

  scv_video_timing #(.CE_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_ce(b_pix_ce), .hcnt(b_hcnt), .vcnt(b_vcnt),
    .hsync(b_hsync), .vsync(b_vsync), .hblank(b_hblank), .vblank(b_vblank), .vbl(b_vbl),
    .frame_start(b_frame_start), .vram_req(b_req), .vram_a(b_vram_a), .vram_ack(b_ack),
    .vram_di(b_di), .tile_q(b_tile_q), .tile_valid(b_tile_valid), .fetch_late(b_late),
    .late_clr(b_late_clr)
  );

  // ---------------- instance C: reset during WAIT ----------------
  logic       c_rst_n;
  logic       c_ack_en;
  logic       c_pix_ce, c_hsync, c_vsync, c_hblank, c_vblank, c_vbl, c_frame_start;
  logic [8:0] c_hcnt, c_vcnt;
  logic       c_req, c_ack, c_tile_valid, c_late;
  logic [9:0] c_vram_a;
  logic [7:0] c_di, c_tile_q;
  logic       c_late_clr = 1'b0;

  // Arbiter model for C: grants in the same cycle whenever enabled.
  assign c_ack = c_ack_en & c_req;
  assign c_di  = c_vram_a[7:0];

  scv_video_timing #(.CE_DIV(1)) dut_c (
    .clk(clk), .rst_n(c_rst_n), .pix_ce(c_pix_ce), .hcnt(c_hcnt), .vcnt(c_vcnt),
    .hsync(c_hsync), .vsync(c_vsync), .hblank(c_hblank), .vblank(c_vblank), .vbl(c_vbl),
    .frame_start(c_frame_start), .vram_req(c_req), .vram_a(c_vram_a), .vram_ack(c_ack),
    .vram_di(c_di), .tile_q(c_tile_q), .tile_valid(c_tile_valid), .fetch_late(c_late),
    .late_clr(c_late_clr)
  );

  // Instance A: every output compared each cycle against the model.
  task automatic run_a();
    bit         m_req  = 1'b0;
    bit         m_tv   = 1'b0;
    bit         m_late = 1'b0;
    logic [9:0] m_addr = '0;
    logic [7:0] m_tile = '0;
    int         m_age  = 0;
    logic [7:0] saved_tile = '0;
    int         tv_cnt = 0;
    bit         prev_req = 1'b0;
    logic [9:0] l1_addr[$];
    for (int n = 0; n < A_CYCLES; n++) begin
      int         p, h, v;
      bit         frame1, slot, old_req, fresh;
      logic [9:0] saddr;
      p = pix_adv(n, 1);
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      frame1 = (n < FRAME);

      check("a_pix_ce", 32'(a_pix_ce), 32'(exp_ce(n, 1)));
      check("a_hcnt", 32'(a_hcnt), h);
      check("a_vcnt", 32'(a_vcnt), v);
      check("a_hsync", 32'(a_hsync), 32'(h >= 216 && h < 236));
      check("a_vsync", 32'(a_vsync), 32'(v >= 240 && v < 243));
      check("a_hblank", 32'(a_hblank), 32'(h >= 192));
      check("a_vblank", 32'(a_vblank), 32'(v >= 222));
      check("a_vbl", 32'(a_vbl), 32'(v >= 222));
      check("a_frame_start", 32'(a_frame_start), 32'(exp_fs(n, 1)));
      check("a_vram_req", 32'(a_req), 32'(m_req));
      check("a_vram_a", 32'(a_vram_a), 32'(m_addr));
      check("a_tile_valid", 32'(a_tile_valid), 32'(m_tv));
      check("a_tile_q", 32'(a_tile_q), 32'(m_tile));
      check("a_fetch_late", 32'(a_late), 32'(m_late));

      // Directed boundary points in the first frame.
      if (n == 0) check("a_ce_first", 32'(a_pix_ce), 0);
      if (n == 1) check("a_ce_second", 32'(a_pix_ce), 1);
      if (n == 192) check("a_hblank_191", 32'(a_hblank), 0);
      if (n == 193) check("a_hblank_192", 32'(a_hblank), 1);
      if (n == 260) begin
        check("a_hcnt_259", 32'(a_hcnt), 259);
        check("a_vcnt_line0", 32'(a_vcnt), 0);
      end
      if (n == 261) begin
        check("a_hcnt_wrap", 32'(a_hcnt), 0);
        check("a_vcnt_line1", 32'(a_vcnt), 1);
      end
      if (frame1 && v == 0 && h == 9) begin
        check("a_late_set", 32'(a_late), 1);
        check("a_addr_repl", 32'(a_vram_a), 32'h001);
        check("a_req_held", 32'(a_req), 1);
      end
      if (frame1 && v == 0 && h == 11) begin
        check("a_late_ack_tv", 32'(a_tile_valid), 1);
        check("a_late_ack_q", 32'(a_tile_q), 32'h01);
      end
      if (frame1 && v == 0 && h == 101) check("a_late_clr", 32'(a_late), 0);
      if (frame1 && v == 1) begin
        if (a_req && !prev_req) l1_addr.push_back(a_vram_a);
        if (a_tile_valid) tv_cnt++;
        if (h == 259) begin
          check("a_l1_fetches", l1_addr.size(), 24);
          check("a_l1_tv_count", tv_cnt, 24);
          for (int i = 0; i < l1_addr.size(); i++) check("a_l1_addr", 32'(l1_addr[i]), i);
        end
      end
      if (frame1 && v == 8 && h == 1) begin
        check("a_l8_req", 32'(a_req), 1);
        check("a_l8_addr", 32'(a_vram_a), 32'h020);
      end
      if (frame1 && v == 2 && h == 200) check("a_idle_before_ack", 32'(a_req), 0);
      if (frame1 && v == 2 && h == 201) begin
        check("a_idle_ack_tv", 32'(a_tile_valid), 0);
        check("a_idle_ack_q", 32'(a_tile_q), 32'(saved_tile));
      end
      if (frame1 && v == 221 && h == 259) check("a_vblank_221", 32'(a_vblank), 0);
      if (frame1 && v == 222 && h == 0) begin
        check("a_vblank_222", 32'(a_vblank), 1);
        check("a_vbl_222", 32'(a_vbl), 1);
      end
      if (frame1 && v == 239 && h == 259) check("a_vsync_239", 32'(a_vsync), 0);
      if (frame1 && v == 240 && h == 0) check("a_vsync_240", 32'(a_vsync), 1);
      if (frame1 && v == 242 && h == 259) check("a_vsync_242", 32'(a_vsync), 1);
      if (frame1 && v == 243 && h == 0) check("a_vsync_243", 32'(a_vsync), 0);
      if (n == FRAME) begin
        check("a_last_h", 32'(a_hcnt), 259);
        check("a_last_v", 32'(a_vcnt), 261);
      end
      if (n == FRAME + 1) check("a_fs_pulse", 32'(a_frame_start), 1);
      if (n == FRAME + 2) check("a_fs_single", 32'(a_frame_start), 0);
      prev_req = a_req;

      // Stimulus for the next edge.
      a_ack = 1'b0;
      a_di = 8'h00;
      a_late_clr = 1'b0;
      if (frame1 && v == 0) begin
        a_ack = (h >= 10) && m_req && (m_age >= 2);
        a_di = m_addr[7:0];
        a_late_clr = (h == 100);
      end else if (frame1 && v < 16) begin
        a_ack = m_req && (m_age >= 2);
        a_di = m_addr[7:0];
        if (v == 2 && h == 200) begin
          a_ack = 1'b1;
          a_di = 8'hA5;
          saved_tile = m_tile;
        end
      end else begin
        a_ack = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        a_di = 8'($urandom);
        a_late_clr = ($urandom_range(0, 63) == 0);
      end

      // Reference model for the fetch port, evaluated at the coming edge.
      slot = exp_ce(n, 1) && (h % 8 == 0) && (h < 192) && (v < 222);
      saddr = 10'(((v / 8) % 32) * 32 + (h / 8) % 32);
      old_req = m_req;
      fresh = 1'b0;
      m_tv = 1'b0;
      if (a_late_clr) m_late = 1'b0;
      if (m_req) begin
        if (a_ack) begin
          m_tile = a_di;
          m_tv = 1'b1;
          if (slot) begin
            m_addr = saddr;
            fresh = 1'b1;
          end else begin
            m_req = 1'b0;
          end
        end else if (slot) begin
          m_late = 1'b1;
          m_addr = saddr;
        end
      end else if (slot) begin
        m_req = 1'b1;
        m_addr = saddr;
        fresh = 1'b1;
      end
      if (!m_req) m_age = 0;
      else if (fresh || !old_req) m_age = 1;
      else m_age++;

      @(negedge clk);
    end
  endtask

  // Instance B: divider cadence and line length with CE_DIV = 4.
  task automatic run_b();
    int ce_ones = 0;
    int n1 = -1;
    int n2 = -1;
    for (int n = 0; n < 2400; n++) begin
      int p;
      p = pix_adv(n, 4);
      check("b_pix_ce", 32'(b_pix_ce), 32'(exp_ce(n, 4)));
      check("b_hcnt", 32'(b_hcnt), p % H_TOT);
      check("b_vcnt", 32'(b_vcnt), (p / H_TOT) % V_TOT);
      if (n >= 1 && n <= 400 && b_pix_ce) ce_ones++;
      if (b_vcnt == 9'd1 && n1 < 0) n1 = n;
      if (b_vcnt == 9'd2 && n2 < 0) n2 = n;
      @(negedge clk);
    end
    check("b_ce_duty", ce_ones, 100);
    check("b_line_len", n2 - n1, 1040);
  endtask

  // Instance C: async reset while a late request is outstanding on line 100.
  task automatic run_c();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (c_vcnt == 9'd99 && c_hcnt == 9'd250) begin
        found = 1'b1;
        break;
      end
    end
    check("c_reach_line99", 32'(found), 1);
    c_ack_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (c_vcnt == 9'd100 && c_hcnt == 9'd12) begin
        found = 1'b1;
        break;
      end
    end
    check("c_reach_line100", 32'(found), 1);
    check("c_pre_req", 32'(c_req), 1);
    check("c_pre_late", 32'(c_late), 1);
    check("c_pre_addr", 32'(c_vram_a), 32'h181);
    check("c_pre_tile", 32'(c_tile_q), 32'h97);

    // Assert reset between clock edges; everything must clear at once.
    #2 c_rst_n = 1'b0;
    #1;
    check("c_rst_req", 32'(c_req), 0);
    check("c_rst_hcnt", 32'(c_hcnt), 0);
    check("c_rst_vcnt", 32'(c_vcnt), 0);
    check("c_rst_tile", 32'(c_tile_q), 0);
    check("c_rst_late", 32'(c_late), 0);
    check("c_rst_addr", 32'(c_vram_a), 0);
    check("c_rst_pix_ce", 32'(c_pix_ce), 0);
    check("c_rst_vblank", 32'(c_vblank), 0);

    c_ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    c_rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("c_restart_req", 32'(c_req), 1);
    check("c_restart_addr", 32'(c_vram_a), 0);
    check("c_restart_hcnt", 32'(c_hcnt), 1);
    check("c_restart_vcnt", 32'(c_vcnt), 0);
    check("c_restart_fs", 32'(c_frame_start), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    c_rst_n = 1'b0;
    c_ack_en = 1'b1;
    a_ack = 1'b1;
    a_di = 8'hFF;
    a_late_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state, with a grant held high to show it is ignored.
    check("rst_pix_ce", 32'(a_pix_ce), 0);
    check("rst_hcnt", 32'(a_hcnt), 0);
    check("rst_vcnt", 32'(a_vcnt), 0);
    check("rst_hsync", 32'(a_hsync), 0);
    check("rst_vsync", 32'(a_vsync), 0);
    check("rst_hblank", 32'(a_hblank), 0);
    check("rst_vblank", 32'(a_vblank), 0);
    check("rst_vbl", 32'(a_vbl), 0);
    check("rst_frame_start", 32'(a_frame_start), 0);
    check("rst_vram_req", 32'(a_req), 0);
    check("rst_vram_a", 32'(a_vram_a), 0);
    check("rst_tile_q", 32'(a_tile_q), 0);
    check("rst_tile_valid", 32'(a_tile_valid), 0);
    check("rst_fetch_late", 32'(a_late), 0);
    check("rst_b_pix_ce", 32'(b_pix_ce), 0);

    a_ack = 1'b0;
    a_di = 8'h00;
    rst_n = 1'b1;
    c_rst_n = 1'b1;
    fork
      run_a();
      run_b();
      run_c();
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
